// File: rtl/single_int_frac_split_if.sv
// Operand/result handshake bundle for the single-precision int/frac splitter.
interface single_int_frac_split_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] int_part;
   logic [31:0] frac_part;

   modport master (
      output in_valid, a, out_ready,
      input  in_ready, out_valid, int_part, frac_part
   );

   modport slave (
      input  in_valid, a, out_ready,
      output in_ready, out_valid, int_part, frac_part
   );
endinterface

// File: rtl/single_int_frac_split.sv
// Splits an IEEE-754 single into truncated integer part and signed fractional part;
// the fraction is normalized by a one-bit-per-cycle left shifter.
module single_int_frac_split (
   input  logic                    clk,
   input  logic                    rstn,
   single_int_frac_split_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_r;
   logic        in_ready_r;
   logic        out_valid_r;
   logic [31:0] int_r;
   logic [31:0] frac_r;
   logic        sign_r;
   logic [7:0]  e_r;
   logic [22:0] r_r;

   logic        sign_s;
   logic [7:0]  exp_s;
   logic [22:0] man_s;
   logic [4:0]  sh_s;
   logic [22:0] mask_s;
   logic [22:0] frac_bits_s;
   logic [31:0] nxt_int_s;
   logic [31:0] nxt_frac_s;
   logic        nxt_norm_s;
   logic [7:0]  e_dec_s;

   // Classify the incoming operand and compute the bypass results.
   always_comb begin
      sign_s      = bus.a[31];
      exp_s       = bus.a[30:23];
      man_s       = bus.a[22:0];
      // Number of fraction bits is 150-e; for 127<=e<=149 this equals (22-e) mod 32.
      sh_s        = 5'd22 - exp_s[4:0];
      mask_s      = ~(23'h7FFFFF << sh_s);
      frac_bits_s = man_s & mask_s;
      nxt_int_s   = bus.a;
      nxt_frac_s  = bus.a;
      nxt_norm_s  = 1'b0;
      e_dec_s     = e_r - 8'd1;
      if (exp_s == 8'hFF) begin
         nxt_int_s  = bus.a;
         nxt_frac_s = 32'h7FC00000;
      end else if (exp_s >= 8'd150) begin
         nxt_int_s  = bus.a;
         nxt_frac_s = {sign_s, 31'd0};
      end else if (exp_s < 8'd127) begin
         nxt_int_s  = {sign_s, 31'd0};
         nxt_frac_s = bus.a;
      end else begin
         nxt_int_s = {sign_s, exp_s, man_s & ~mask_s};
         if (frac_bits_s == 23'd0) begin
            nxt_frac_s = {sign_s, 31'd0};
         end else begin
            nxt_frac_s = bus.a;
            nxt_norm_s = 1'b1;
         end
      end
   end

   // Control FSM with registered handshake outputs and normalizing shifter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         int_r       <= 32'd0;
         frac_r      <= 32'd0;
         sign_r      <= 1'b0;
         e_r         <= 8'd0;
         r_r         <= 23'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  int_r      <= nxt_int_s;
                  sign_r     <= sign_s;
                  in_ready_r <= 1'b0;
                  if (nxt_norm_s) begin
                     r_r     <= frac_bits_s;
                     e_r     <= exp_s;
                     state_r <= SHIFT;
                  end else begin
                     frac_r      <= nxt_frac_s;
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end
               end
            end
            SHIFT: begin
               r_r <= {r_r[21:0], 1'b0};
               e_r <= e_dec_s;
               if (r_r[22]) begin
                  frac_r      <= {sign_r, e_dec_s, r_r[21:0], 1'b0};
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.int_part  = int_r;
   assign bus.frac_part = frac_r;

endmodule

// File: tb/tb_single_int_frac_split.sv
// Directed, table-driven bench for single_int_frac_split with handshake and reset corner cases.
module tb_single_int_frac_split;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_err;

   single_int_frac_split_if bus ();

   single_int_frac_split dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] exp_int;
      logic [31:0] exp_frac;
      int          exp_n;
   } vec_t;

   vec_t vecs [12];

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   task automatic start_op(input logic [31:0] op, input string nm);
      @(negedge clk);
      check32({nm, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      bus.a         = op;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = 32'hDEADBEEF;
   endtask

   task automatic wait_result(input logic [31:0] ei, input logic [31:0] ef,
                              input int en, input string nm);
      int n;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check32({nm, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check32({nm, " latency"}, n, en);
      check32({nm, " int_part"}, bus.int_part, ei);
      check32({nm, " frac_part"}, bus.frac_part, ef);
   endtask

   task automatic release_result(input string nm);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check32({nm, " out_valid after release"}, {31'd0, bus.out_valid}, 32'd0);
      check32({nm, " in_ready after release"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      vecs[0]  = '{"1.5",       32'h3FC00000, 32'h3F800000, 32'h3F000000, 1};
      vecs[1]  = '{"-2.75",     32'hC0300000, 32'hC0000000, 32'hBF400000, 2};
      vecs[2]  = '{"1+ulp",     32'h3F800001, 32'h3F800000, 32'h34000000, 23};
      vecs[3]  = '{"0.25",      32'h3E800000, 32'h00000000, 32'h3E800000, 0};
      vecs[4]  = '{"2^24",      32'h4B800000, 32'h4B800000, 32'h00000000, 0};
      vecs[5]  = '{"inf",       32'h7F800000, 32'h7F800000, 32'h7FC00000, 0};
      vecs[6]  = '{"-nan",      32'hFFC00001, 32'hFFC00001, 32'h7FC00000, 0};
      vecs[7]  = '{"-0",        32'h80000000, 32'h80000000, 32'h80000000, 0};
      vecs[8]  = '{"denorm",    32'h00000001, 32'h00000000, 32'h00000001, 0};
      vecs[9]  = '{"pi",        32'h40490FDB, 32'h40400000, 32'h3E10FDB0, 4};
      vecs[10] = '{"e149",      32'h4AFFFFFF, 32'h4AFFFFFE, 32'h3F000000, 23};
      vecs[11] = '{"e150",      32'h4B000001, 32'h4B000001, 32'h00000000, 0};

      rstn          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = 32'd0;
      bus.out_ready = 1'b0;
      #12;
      check32("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check32("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check32("reset int_part", bus.int_part, 32'd0);
      check32("reset frac_part", bus.frac_part, 32'd0);
      @(posedge clk);
      #2;
      rstn = 1'b1;

      for (int i = 0; i < 12; i++) begin
         start_op(vecs[i].a, vecs[i].name);
         wait_result(vecs[i].exp_int, vecs[i].exp_frac, vecs[i].exp_n, vecs[i].name);
         release_result(vecs[i].name);
      end

      // Back-pressure: result must hold and a second operand must be ignored.
      start_op(32'h3FC00000, "hold");
      wait_result(32'h3F800000, 32'h3F000000, 1, "hold");
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = 1'b1;
         bus.a        = 32'h40490FDB;
         @(posedge clk);
         #1;
         check32("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
         check32("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
         check32("hold int_part", bus.int_part, 32'h3F800000);
         check32("hold frac_part", bus.frac_part, 32'h3F000000);
      end
      bus.in_valid = 1'b0;
      release_result("hold");
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check32("ignored op no out_valid", {31'd0, bus.out_valid}, 32'd0);
      end

      // Reset in the middle of a long normalization.
      start_op(32'h3F800001, "abort");
      repeat (9) @(posedge clk);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check32("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
      check32("abort int_part", bus.int_part, 32'd0);
      check32("abort frac_part", bus.frac_part, 32'd0);
      check32("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #2;
      check32("abort held out_valid", {31'd0, bus.out_valid}, 32'd0);
      rstn = 1'b1;
      start_op(32'h3FC00000, "post-reset");
      wait_result(32'h3F800000, 32'h3F000000, 1, "post-reset");
      release_result("post-reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/single_int_frac_split.md
SINGLE_INT_FRAC_SPLIT -- requirements
Module: single_int_frac_split

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 in_valid  input  1  operand a is valid.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 a  input  32  IEEE-754 single operand.
REQ-007 out_valid  output  1  int_part and frac_part are valid, registered.
REQ-008 out_ready  input  1  downstream (the 2^int / 2^frac stages) accepts the result.
REQ-009 int_part  output  32  single: a truncated toward zero.
REQ-010 frac_part  output  32  single: a - int_part, sign of a.

Function
REQ-011 The module SHALL accept an operand on a rising edge T0 where in_valid && in_ready.
REQ-012 Field definitions SHALL be s=a[31], e=a[30:23], m=a[22:0], k=e-127.
REQ-013 e==255 SHALL give int_part=a and frac_part=32'h7FC00000.
REQ-014 e>=150 and e!=255 SHALL give int_part=a and frac_part={s,31'b0}.
REQ-015 e<127, including zero and denormals, SHALL give int_part={s,31'b0} and frac_part=a.
REQ-016 127<=e<=149 SHALL give int_part={s,e,m with low 23-k bits cleared}.
REQ-017 In the 127<=e<=149 case, F = m & ((1<<(23-k))-1).
REQ-018 F==0 SHALL give frac_part={s,31'b0}.
REQ-019 F!=0 SHALL normalize via a 24-bit R=F and 8-bit E=e, shifting R left one bit and decrementing E by 1 per cycle until R[23]=1; frac_part={s,E,R[22:0]}.
REQ-020 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-021 IDLE SHALL go to SHIFT on accept when normalization is required (REQ-019), else to DONE.
REQ-022 SHIFT SHALL perform one shift per cycle and go to DONE on the cycle whose pre-shift R[22]==1.
REQ-023 DONE SHALL go to IDLE on an edge with out_ready==1.
REQ-024 out_valid SHALL be high exactly while in DONE.
REQ-025 Latency: out_valid SHALL rise at edge T0+n, where n is the number of shifts (0 for bypass cases; 1..23 otherwise; n = 23 - msb index of F).
REQ-026 While out_valid && !out_ready, int_part, frac_part and out_valid SHALL hold stable.
REQ-027 in_ready SHALL be low in SHIFT and DONE; the block SHALL never overlap operations.
REQ-028 in_valid while in_ready is low SHALL be ignored and the operand SHALL NOT be latched.
REQ-029 a SHALL be sampled only at T0; later changes on a SHALL NOT affect the result.
REQ-030 E SHALL never underflow, since the minimum is e-23 >= 104.

Reset
REQ-031 rstn low SHALL immediately force state=IDLE, out_valid=0, int_part=0, frac_part=0 and in_ready=1, independent of clk.
REQ-032 Reset asserted during SHIFT or DONE SHALL abandon the operation with no output produced.
REQ-033 The first accept SHALL be possible on the first rising edge after rstn deasserts.

Verification
REQ-034 a=0x3FC00000 (1.5), out_ready=1 -> int_part=0x3F800000, frac_part=0x3F000000, n=1, out_valid at T0+1.
REQ-035 a=0xC0300000 (-2.75) -> int_part=0xC0000000, frac_part=0xBF400000, n=2.
REQ-036 a=0x3F800001 -> int_part=0x3F800000, frac_part=0x34000000, n=23; a=0x3E800000 (0.25) -> int_part=0x00000000, frac_part=0x3E800000, n=0.
REQ-037 a=0x4B800000 (2^24) -> int_part=0x4B800000, frac_part=0x00000000; a=0x7F800000 -> int_part=0x7F800000, frac_part=0x7FC00000.
REQ-038 a=1.5 with out_ready held low 5 cycles -> outputs stable, in_ready=0, second in_valid ignored; result released on the first out_ready edge, then in_ready=1.
REQ-039 a=0x3F800001 with rstn pulsed low at T0+10 -> outputs 0 asynchronously, no out_valid; a new operand 1.5 is accepted after release and gives correct results.
